// File: rtl/dll_pkg.sv
// Shared definitions for the data link layer RX/TX path.
// Holds frame field widths, CRC constants, the RX state type and the
// LFSR / CRC helper functions used by both directions of the link.
package dll_pkg;

    localparam int FRAME_W = 128;
    localparam int TLP_W   = 96;
    localparam int SEQ_W   = 16;
    localparam int CRC_W   = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        RUN       = 1'b0,
        NAK_SCHED = 1'b1
    } rx_state_t;

    function automatic logic [SEQ_W-1:0] lfsr_next(input logic [SEQ_W-1:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    // CRC-16-CCITT, MSB first, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc16_calc(input logic [SEQ_W+TLP_W-1:0] data);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = CRC_INIT;
        for (int i = SEQ_W + TLP_W - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ data[i];
            crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return crc;
    endfunction

endpackage

// File: rtl/dll_rx_checker_if.sv
// Bus bundle between the link receiver and its neighbours.
//   frame_*  : incoming frames {seq, tlp, crc} with valid/ready
//   tlp_*    : checked TLP payload towards the transaction layer
//   dllp_*   : ACK/NAK request towards the DLLP formatter
//   nak_sched, err_crc_cnt : status
// master = the side feeding frames and consuming TLP/DLLP, slave = the checker.
interface dll_rx_checker_if;
    import dll_pkg::*;

    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic               frame_ready;
    logic [TLP_W-1:0]   tlp_out;
    logic               tlp_valid;
    logic               tlp_ready;
    logic               dllp_valid;
    logic               dllp_is_nak;
    logic [SEQ_W-1:0]   dllp_seq;
    logic               dllp_ready;
    logic               nak_sched;
    logic [7:0]         err_crc_cnt;

    modport master (
        output frame_in, frame_valid, tlp_ready, dllp_ready,
        input  frame_ready, tlp_out, tlp_valid, dllp_valid, dllp_is_nak,
               dllp_seq, nak_sched, err_crc_cnt
    );

    modport slave (
        input  frame_in, frame_valid, tlp_ready, dllp_ready,
        output frame_ready, tlp_out, tlp_valid, dllp_valid, dllp_is_nak,
               dllp_seq, nak_sched, err_crc_cnt
    );

endinterface

// File: rtl/dll_crc16_chk.sv
// Combinational CRC check of a received frame.
//   frame  : {seq, tlp, crc}
//   crc_ok : 1 when the CRC field matches the CRC over {seq, tlp}
module dll_crc16_chk
    import dll_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               crc_ok
);

    assign crc_ok = (crc16_calc(frame[FRAME_W-1:CRC_W]) == frame[CRC_W-1:0]);

endmodule

// File: rtl/dll_rx_checker.sv
// Receive-side data link layer checker.
// Verifies CRC and sequence number of each frame, forwards good TLPs and
// raises ACK/NAK requests towards the replay buffer of the transmitter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame input, TLP output, DLLP request and status (slave side)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | in sequence; bad or out-of-order frames post a NAK
// NAK_SCHED | NAK outstanding; everything but the expected seq is dropped
module dll_rx_checker
    import dll_pkg::*;
#(
    parameter logic [SEQ_W-1:0] SEQ_SEED  = 16'h0001,
    parameter int               ACK_LIMIT = 4,
    parameter int               ACK_TIMER = 32
) (
    input logic              clk,
    input logic              rst,
    dll_rx_checker_if.slave  bus
);

    localparam int CNT_W = $clog2(ACK_LIMIT + 1);
    localparam int TMR_W = $clog2(ACK_TIMER + 1);

    rx_state_t          state_q, state_d;
    logic [SEQ_W-1:0]   exp_seq_q, exp_seq_d;
    logic [SEQ_W-1:0]   last_good_q, last_good_d;
    logic               any_good_q, any_good_d;
    logic [TLP_W-1:0]   tlp_out_q, tlp_out_d;
    logic               tlp_valid_q, tlp_valid_d;
    logic               dllp_valid_q, dllp_valid_d;
    logic               dllp_is_nak_q, dllp_is_nak_d;
    logic [SEQ_W-1:0]   dllp_seq_q, dllp_seq_d;
    logic [7:0]         err_q, err_d;
    logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [TMR_W-1:0]   ack_tmr_q, ack_tmr_d;

    logic               crc_ok;
    logic               taken;
    logic [SEQ_W-1:0]   seq;
    logic               good;
    logic               post_nak;
    logic               post_ack;
    logic               dllp_accept;

    dll_crc16_chk u_crc (
        .frame  (bus.frame_in),
        .crc_ok (crc_ok)
    );

    assign seq             = bus.frame_in[FRAME_W-1 -: SEQ_W];
    assign bus.frame_ready = !tlp_valid_q || bus.tlp_ready;
    assign taken           = bus.frame_valid && bus.frame_ready;
    assign dllp_accept     = dllp_valid_q && bus.dllp_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        exp_seq_d     = exp_seq_q;
        last_good_d   = last_good_q;
        any_good_d    = any_good_q;
        tlp_out_d     = tlp_out_q;
        tlp_valid_d   = tlp_valid_q;
        dllp_valid_d  = dllp_valid_q;
        dllp_is_nak_d = dllp_is_nak_q;
        dllp_seq_d    = dllp_seq_q;
        err_d         = err_q;
        ack_cnt_d     = ack_cnt_q;
        ack_tmr_d     = ack_tmr_q;
        good          = 1'b0;
        post_nak      = 1'b0;
        post_ack      = 1'b0;

        if (tlp_valid_q && bus.tlp_ready) tlp_valid_d = 1'b0;

        if (taken) begin
            if (!crc_ok) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
                post_nak = (state_q == RUN);
            end else if (seq == exp_seq_q) begin
                good        = 1'b1;
                tlp_out_d   = bus.frame_in[CRC_W +: TLP_W];
                tlp_valid_d = 1'b1;
                last_good_d = seq;
                exp_seq_d   = lfsr_next(exp_seq_q);
                any_good_d  = 1'b1;
            end else if (state_q == RUN) begin
                // A replay of the last good frame means our ACK was lost.
                if (any_good_q && seq == last_good_q) post_ack = 1'b1;
                else                                  post_nak = 1'b1;
            end
        end

        case (state_q)
            RUN:       if (post_nak) state_d = NAK_SCHED;
            NAK_SCHED: if (good)     state_d = RUN;
            default:   state_d = RUN;
        endcase

        if (good && ack_cnt_q == CNT_W'(ACK_LIMIT - 1))         post_ack = 1'b1;
        if (ack_cnt_q != '0 && ack_tmr_q == TMR_W'(ACK_TIMER - 1)) post_ack = 1'b1;

        // Any ACK carries last_good_d, so it also covers a frame taken this cycle.
        if (post_ack) begin
            ack_cnt_d = '0;
            ack_tmr_d = '0;
        end else begin
            ack_cnt_d = ack_cnt_q + CNT_W'(good);
            ack_tmr_d = (ack_cnt_q != '0) ? ack_tmr_q + TMR_W'(1) : '0;
        end

        if (dllp_accept) dllp_valid_d = 1'b0;

        if (post_nak) begin
            dllp_valid_d  = 1'b1;
            dllp_is_nak_d = 1'b1;
            dllp_seq_d    = last_good_d;
        end else if (post_ack && !(dllp_valid_q && dllp_is_nak_q && !dllp_accept)) begin
            dllp_valid_d  = 1'b1;
            dllp_is_nak_d = 1'b0;
            dllp_seq_d    = last_good_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_seq_q     <= SEQ_SEED;
            last_good_q   <= '0;
            any_good_q    <= 1'b0;
            tlp_out_q     <= '0;
            tlp_valid_q   <= 1'b0;
            dllp_valid_q  <= 1'b0;
            dllp_is_nak_q <= 1'b0;
            dllp_seq_q    <= '0;
            err_q         <= '0;
            ack_cnt_q     <= '0;
            ack_tmr_q     <= '0;
        end else begin
            exp_seq_q     <= exp_seq_d;
            last_good_q   <= last_good_d;
            any_good_q    <= any_good_d;
            tlp_out_q     <= tlp_out_d;
            tlp_valid_q   <= tlp_valid_d;
            dllp_valid_q  <= dllp_valid_d;
            dllp_is_nak_q <= dllp_is_nak_d;
            dllp_seq_q    <= dllp_seq_d;
            err_q         <= err_d;
            ack_cnt_q     <= ack_cnt_d;
            ack_tmr_q     <= ack_tmr_d;
        end
    end

    assign bus.tlp_out     = tlp_out_q;
    assign bus.tlp_valid   = tlp_valid_q;
    assign bus.dllp_valid  = dllp_valid_q;
    assign bus.dllp_is_nak = dllp_is_nak_q;
    assign bus.dllp_seq    = dllp_seq_q;
    assign bus.nak_sched   = (state_q == NAK_SCHED);
    assign bus.err_crc_cnt = err_q;

endmodule

// File: tb/tb_dll_rx_checker.sv
// Testbench for dll_rx_checker: directed scenarios plus a randomized
// stream, checked against a transaction-level model of the link rules.
module tb_dll_rx_checker;

    localparam int ACK_LIMIT = 4;
    localparam int ACK_TIMER = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dll_rx_checker_if bus();

    dll_rx_checker #(
        .SEQ_SEED  (16'h0001),
        .ACK_LIMIT (ACK_LIMIT),
        .ACK_TIMER (ACK_TIMER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Sequence numbers in the order the transmitter emits them.
    logic [15:0] seq_tab [4096];

    logic [95:0] q_tlp  [$];
    logic [16:0] q_dllp [$];

    // Model: m_idx = number of frames accepted in order since reset.
    int          m_idx, m_unacked, m_first, m_cyc, m_err;
    logic        m_tv, m_nak, m_dv, m_dnak;
    logic [15:0] m_dseq;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [111:0] m);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 112; i++) begin
            if (c[15] ^ m[111]) c = (c << 1) ^ 16'h1021;
            else                c = c << 1;
            m = m << 1;
        end
        return c;
    endfunction

    function automatic logic [127:0] mk(input logic [15:0] s, input logic [95:0] t, input int flip);
        logic [127:0] f;
        f = {s, t, ref_crc({s, t})};
        if (flip >= 0) f[flip] = ~f[flip];
        return f;
    endfunction

    function automatic logic [95:0] rtlp();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] last_good();
        return (m_idx == 0) ? 16'h0000 : seq_tab[m_idx-1];
    endfunction

    task automatic model_reset();
        m_idx = 0; m_unacked = 0; m_first = 0; m_err = 0;
        m_tv = 0; m_nak = 0; m_dv = 0; m_dnak = 0; m_dseq = '0;
        q_tlp.delete();
        q_dllp.delete();
    endtask

    task automatic model_edge(input logic fv, input logic [127:0] f, input logic tr, input logic dr);
        logic        taken, good, nak_post, ack_post, timer_due;
        logic [15:0] s;
        s         = f[127:112];
        taken     = fv && (!m_tv || tr);
        good      = 0;
        nak_post  = 0;
        ack_post  = 0;
        timer_due = (m_unacked > 0) && (m_cyc - m_first == ACK_TIMER);
        if (m_dv && dr) begin
            q_dllp.push_back({m_dnak, m_dseq});
            m_dv = 0;
        end
        if (m_tv && tr) m_tv = 0;
        if (taken) begin
            if (ref_crc(f[127:16]) != f[15:0]) begin
                if (m_err < 255) m_err++;
                if (!m_nak) begin nak_post = 1; m_nak = 1; end
            end else if (s == seq_tab[m_idx]) begin
                q_tlp.push_back(f[111:16]);
                m_tv = 1; m_idx++; m_nak = 0; good = 1;
            end else if (!m_nak && m_idx > 0 && s == seq_tab[m_idx-1]) begin
                ack_post = 1;
            end else if (!m_nak) begin
                nak_post = 1; m_nak = 1;
            end
        end
        if (good) begin
            if (m_unacked == 0) m_first = m_cyc;
            m_unacked++;
            if (m_unacked == ACK_LIMIT) ack_post = 1;
        end
        if (timer_due) ack_post = 1;
        if (ack_post) m_unacked = 0;
        if (nak_post) begin
            m_dv = 1; m_dnak = 1; m_dseq = last_good();
        end else if (ack_post && !(m_dv && m_dnak)) begin
            m_dv = 1; m_dnak = 0; m_dseq = last_good();
        end
    endtask

    // One clock cycle: drive at negedge, check registered outputs, advance model.
    task automatic step(input logic r, input logic fv, input logic [127:0] f,
                        input logic tr, input logic dr);
        @(negedge clk);
        rst             = r;
        bus.frame_valid = fv;
        bus.frame_in    = f;
        bus.tlp_ready   = tr;
        bus.dllp_ready  = dr;
        #1;
        chk("frame_ready", bus.frame_ready, !m_tv || tr);
        chk("tlp_valid", bus.tlp_valid, m_tv);
        chk("dllp_valid", bus.dllp_valid, m_dv);
        chk("nak_sched", bus.nak_sched, m_nak);
        chk("err_crc_cnt", bus.err_crc_cnt, m_err[7:0]);
        if (m_dv) chk("dllp_content", {bus.dllp_is_nak, bus.dllp_seq}, {m_dnak, m_dseq});
        if (r) model_reset();
        else   model_edge(fv, f, tr, dr);
        m_cyc++;
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0);
        step(1, 0, '0, 0, 0);
    endtask

    task automatic send(input logic [127:0] f, input logic tr, input logic dr);
        step(0, 1, f, tr, dr);
    endtask

    task automatic idle(input int n, input logic tr, input logic dr);
        for (int i = 0; i < n; i++) step(0, 0, '0, tr, dr);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] s;
            int          k, flip;
            k    = int'($urandom_range(9));
            flip = -1;
            s    = seq_tab[m_idx];
            case (k)
                5: flip = int'($urandom_range(127));
                6: s = (m_idx > 0) ? seq_tab[m_idx-1] : 16'h1234;
                7: s = 16'($urandom);
                8: s = (m_idx > 1) ? seq_tab[m_idx-2] : 16'h0000;
                9: s = seq_tab[m_idx+1];
                default: ;
            endcase
            step(0, $urandom_range(3) != 0, mk(s, rtlp(), flip),
                 $urandom_range(3) != 0, $urandom_range(2) != 0);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake the DUT presents.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus.tlp_valid && bus.tlp_ready) begin
                    if (q_tlp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL tlp_unexpected: got %0h expected none at %0t", bus.tlp_out, $time);
                    end else chk("tlp_out", bus.tlp_out, q_tlp.pop_front());
                end
                if (bus.dllp_valid && bus.dllp_ready) begin
                    if (q_dllp.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dllp_unexpected: got %0h expected none at %0t",
                                 {bus.dllp_is_nak, bus.dllp_seq}, $time);
                    end else chk("dllp", {bus.dllp_is_nak, bus.dllp_seq}, q_dllp.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] ta, tb2;
        logic [15:0] p;
        int          k;

        bus.frame_valid = 0;
        bus.frame_in    = '0;
        bus.tlp_ready   = 0;
        bus.dllp_ready  = 0;
        seq_tab[0] = 16'h0001;
        for (int i = 1; i < 4096; i++) begin
            p = seq_tab[i-1];
            seq_tab[i] = {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
        end
        m_cyc = 0;
        model_reset();

        // In-order stream with coalesced ACK after ACK_LIMIT frames
        do_reset();
        send(mk(16'h0001, rtlp(), -1), 1, 1);
        send(mk(16'h0002, rtlp(), -1), 1, 1);
        send(mk(16'h0004, rtlp(), -1), 1, 1);
        ta = rtlp();
        send(mk(16'h0008, ta, -1), 1, 1);
        idle(1, 1, 1);
        chk("inorder_ack_valid", {bus.dllp_valid, bus.dllp_is_nak}, 2'b10);
        chk("inorder_ack_seq", bus.dllp_seq, 16'h0008);
        chk("inorder_tlp", bus.tlp_out, ta);
        chk("inorder_nak_sched", bus.nak_sched, 1'b0);
        idle(3, 1, 1);

        // CRC error then recovery
        do_reset();
        send(mk(16'h0001, rtlp(), -1), 1, 0);
        send(mk(16'h0002, rtlp(), 40), 1, 0);
        idle(1, 1, 0);
        chk("crc_nak", {bus.dllp_valid, bus.dllp_is_nak, bus.dllp_seq}, {2'b11, 16'h0001});
        chk("crc_nak_sched", bus.nak_sched, 1'b1);
        chk("crc_err_cnt", bus.err_crc_cnt, 8'd1);
        chk("crc_no_tlp", bus.tlp_valid, 1'b0);
        idle(2, 1, 1);
        send(mk(16'h0004, rtlp(), -1), 1, 1);
        idle(1, 1, 1);
        chk("rec_silent", {bus.dllp_valid, bus.nak_sched}, 2'b01);
        ta = rtlp();
        send(mk(16'h0002, ta, -1), 1, 1);
        idle(1, 1, 1);
        chk("rec_tlp", {bus.tlp_valid, bus.tlp_out}, {1'b1, ta});
        chk("rec_nak_clr", bus.nak_sched, 1'b0);
        tb2 = rtlp();
        send(mk(16'h0004, tb2, -1), 1, 1);
        idle(1, 1, 1);
        chk("rec_next_seq", {bus.tlp_valid, bus.tlp_out}, {1'b1, tb2});

        // Duplicate frame triggers immediate ACK
        do_reset();
        send(mk(16'h0001, rtlp(), -1), 1, 0);
        send(mk(16'h0002, rtlp(), -1), 1, 0);
        send(mk(16'h0002, rtlp(), -1), 1, 0);
        idle(1, 1, 0);
        chk("dup_ack", {bus.dllp_valid, bus.dllp_is_nak, bus.dllp_seq}, {2'b10, 16'h0002});
        ta = rtlp();
        send(mk(16'h0004, ta, -1), 1, 1);
        idle(1, 1, 1);
        chk("dup_exp_seq", {bus.tlp_valid, bus.nak_sched, bus.tlp_out}, {2'b10, ta});

        // Backpressure, then ACK timer from a single frame
        do_reset();
        ta = rtlp();
        send(mk(16'h0001, ta, -1), 0, 1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            send(mk(16'h0002, rtlp(), -1), 0, 1);
            k++;
            chk("bp_frame_ready", bus.frame_ready, 1'b0);
            chk("bp_tlp_stable", bus.tlp_out, ta);
        end
        while (!bus.dllp_valid && k < 100) begin
            idle(1, 1, 1);
            k++;
        end
        chk("ack_timer_latency", k - 1, ACK_TIMER);
        chk("ack_timer_seq", bus.dllp_seq, 16'h0001);
        idle(2, 1, 1);

        // Reset with a TLP held and a NAK pending
        do_reset();
        send(mk(16'h0005, rtlp(), -1), 1, 0);
        send(mk(16'h0001, rtlp(), -1), 0, 0);
        idle(1, 0, 0);
        chk("pre_rst_state", {bus.tlp_valid, bus.dllp_valid, bus.dllp_is_nak}, 3'b111);
        step(1, 0, '0, 0, 0);
        idle(1, 0, 0);
        chk("rst_outputs", {bus.tlp_valid, bus.dllp_valid, bus.dllp_is_nak, bus.dllp_seq,
                            bus.nak_sched, bus.err_crc_cnt}, '0);
        ta = rtlp();
        send(mk(16'h0001, ta, -1), 1, 1);
        idle(1, 1, 1);
        chk("rst_exp_seq", {bus.tlp_valid, bus.tlp_out}, {1'b1, ta});

        // CRC error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) send(mk(16'h0001, rtlp(), int'($urandom_range(127))), 1, 1);
        idle(1, 1, 1);
        chk("err_saturate", bus.err_crc_cnt, 8'd255);

        // Randomized stream
        do_reset();
        rand_phase(1500);
        idle(40, 1, 1);
        @(negedge clk);
        #3;
        chk("tlp_queue_empty", q_tlp.size(), 0);
        chk("dllp_queue_empty", q_dllp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dll_rx_checker.md
Name: dll_rx_checker

Overview:
- Receive-side data link layer block, the far end of the TX path that stamps each 96-bit TLP with an LFSR sequence number and a CRC.
- Accepts 128-bit frames and verifies the CRC and the sequence number against its own matching LFSR.
- Forwards good TLPs to the transaction layer and issues ACK/NAK DLLP requests back to the transmitter's replay buffer.

Parameters:
SEQ_SEED, 16'h0001, LFSR reset value; must be non-zero and must equal the TX LFSR seed
ACK_LIMIT, 4, good frames accepted before a coalesced ACK is forced
ACK_TIMER, 32, cycles a pending ACK may wait before it is issued anyway

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_in  in  128  {seq[15:0], tlp[95:0], crc[15:0]}
frame_valid  in  1  frame_in valid
frame_ready  out  1  block can take a frame this cycle
tlp_out  out  96  checked TLP payload
tlp_valid  out  1  tlp_out valid
tlp_ready  in  1  transaction layer accepts tlp_out
dllp_valid  out  1  ACK/NAK request pending
dllp_is_nak  out  1  1 = NAK, 0 = ACK
dllp_seq  out  16  last good sequence number received
dllp_ready  in  1  DLLP formatter accepts the request
nak_sched  out  1  NAK outstanding; frames are being discarded
err_crc_cnt  out  8  saturating count of CRC failures

Behaviour:
- Reset (synchronous, active-high): expected_seq=SEQ_SEED; last_good=16'h0000; tlp_valid=0; dllp_valid=0; dllp_is_nak=0; dllp_seq=0; nak_sched=0; err_crc_cnt=0; ack counter and timer=0. Reset mid-frame drops the frame and any pending DLLP.
- LFSR step: next = {q[14:0], q[15]^q[13]^q[12]^q[10]}. This is identical to the TX side.
- CRC: CRC-16-CCITT, polynomial 16'h1021, init 16'hFFFF, no reflection, no final XOR, computed MSB-first over {seq, tlp} (112 bits). Combinational check.
- Handshake: frame_ready = !tlp_valid || tlp_ready. A frame is taken when frame_valid && frame_ready. A good frame appears on tlp_out exactly 1 cycle later. tlp_valid stays high until tlp_ready.
- Classification of a taken frame, in priority order:
  1. CRC bad: discard; err_crc_cnt++ (saturate at 255). If !nak_sched: post NAK, set nak_sched.
  2. seq == expected_seq: good. Forward the TLP; last_good=seq; expected_seq steps; nak_sched clears; ack counter++.
  3. seq == last_good and at least one frame has been accepted: duplicate (replay). Discard; post an immediate ACK of last_good.
  4. Any other seq: discard. If !nak_sched: post NAK, set nak_sched.
- While nak_sched is set, frames failing check 2 are discarded silently.
- State machine (RUN / NAK_SCHED):
  - RUN -> NAK_SCHED on a CRC failure or an out-of-order frame.
  - NAK_SCHED -> RUN on a good in-order frame.
- ACK generation: post an ACK of last_good when the ack counter reaches ACK_LIMIT, or when the timer reaches ACK_TIMER with the counter non-zero. Posting clears both the counter and the timer. The timer counts only while the counter is non-zero.
- DLLP slot (single entry, held until dllp_valid && dllp_ready):
  - New ACK while an ACK is pending: update dllp_seq in place (coalesce).
  - New NAK replaces a pending ACK.
  - New ACK while a NAK is pending is dropped.
  - dllp_seq always carries last_good, for NAK as well as ACK.
  - If a post and an acceptance happen in the same cycle, the new request is loaded.
- Simultaneous tlp_ready=0 with frame_valid: no frame is taken, and no state changes except the timer.

Decomposition:
- Shared package dll_pkg:
  - FRAME_W=128, TLP_W=96, SEQ_W=16, CRC_W=16
  - CRC_POLY=16'h1021, CRC_INIT=16'hFFFF
  - functions lfsr_next() and crc16_calc(), shared with the TX-side crc/lfsr models
  - typedef rx_state_t {RUN, NAK_SCHED}
- One sub-module: dll_crc16_chk. Purely combinational; input frame, output crc_ok.

Test Plan:
- In-order stream: reset, then frames with seq 0001, 0002, 0004, 0008 and valid CRCs, tlp_ready=1 -> four TLPs out, each 1 cycle after acceptance. One ACK with dllp_seq=0008 after the 4th frame (ACK_LIMIT=4). nak_sched stays 0.
- CRC error: seq 0001 good, then seq 0002 with bit 40 flipped -> no TLP for the bad frame; NAK posted with dllp_seq=0001; nak_sched=1; err_crc_cnt=1.
- Recovery: in NAK_SCHED, send seq 0004 (discarded silently, no second NAK), then seq 0002 valid -> TLP forwarded, nak_sched=0, expected_seq=0004.
- Duplicate: accept 0001 and 0002, resend 0002 -> discarded; immediate ACK with dllp_seq=0002; expected_seq stays 0004.
- Backpressure and timer: hold tlp_ready=0 for 5 cycles with frame_valid=1 -> frame_ready=0, tlp_out stable. Single good frame with dllp_ready=1 -> ACK issued ACK_TIMER=32 cycles later.
- Reset mid-stream: assert rst with tlp_valid=1 and a NAK pending -> the next cycle shows all outputs at reset values and expected_seq=0001.
